ntt_butterfly: RTL and testbench
================================

Name: ntt_butterfly

Overview:
- Cooley-Tukey NTT butterfly over Z_q, q = 65537 (2^16+1). Consumes the 17-bit twiddle value produced by the psi lookup table.
- Computes out0 = (a + b*psi) mod q and out1 = (a - b*psi) mod q.
- 3-stage pipeline with valid/ready handshake. Sits between the NTT coefficient memory read port and its write-back path.
- A sideband tag travels with each operation so the controller can recover the write address.

Parameters:
- DATA_W, 17, coefficient/twiddle width; values in [0, 65536].
- TAG_W, 7, width of the passthrough tag (coefficient-pair address).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  DATA_W  top input coefficient.
- b  in  DATA_W  bottom input coefficient.
- psi  in  DATA_W  twiddle factor from the psi table.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  results valid.
- out_ready  in  1  downstream accepts results.
- out0  out  DATA_W  (a + b*psi) mod q.
- out1  out  DATA_W  (a - b*psi) mod q.
- out_tag  out  TAG_W  in_tag of this result.

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits clear; out_valid=0.
  - out0, out1, out_tag and all data registers = 0.
  - in_ready = 1 once reset is released.
  - Asserting reset mid-operation discards all in-flight operations; nothing is emitted afterwards for them.
- Pipeline advance: enable en = out_ready | ~v3. All three stages shift together when en=1 and hold when en=0.
- in_ready = en (combinational from out_ready and v3).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: exactly 3 cycles from transfer-in to out_valid when not stalled. Throughput is 1 per cycle.
- Bubbles: stage valid bits propagate bubbles. Data registers may load when their stage is invalid, but out0/out1/out_tag are only meaningful while out_valid=1.
- Stage 1:
  - p = b*psi as an unsigned 34-bit product; max is 65536*65536 = 2^32.
  - a and tag are registered alongside p.
- Stage 2 (Fermat reduction):
  - lo = p[15:0], hi = p[33:16].
  - t = lo - hi if lo >= hi, else lo - hi + q.
  - Result t is in [0, 65536]; a and tag are carried forward.
- Stage 3:
  - s = a + t; out0 = s - q if s >= q, else s.
  - d = a - t if a >= t, else a - t + q; out1 = d.
  - Intermediate width is 18 bits.
- Stall: while out_valid=1 and out_ready=0, out0, out1 and out_tag hold stable and no stage advances. No drop, no duplicate.
- Simultaneous transfer-in and transfer-out with a full pipeline is legal and sustains full rate.
- Operand range: a, b, psi must be in [0, 65536]. Results for out-of-range operands are unspecified, and the bench does not drive them.
- Value 65536 (≡ -1) is a legal operand and a legal result. It must be handled in every stage without overflow.

Decomposition:
- Package ntt_pkg holds:
  - constant Q = 65537, DATA_W = 17;
  - a function or constant for the modular add/sub correction.
- Sub-module fermat_mod_mul: stages 1-2, i.e. a 17x17 multiply plus 2^16+1 reduction with an enable input.
  - The top module ntt_butterfly adds stage 3, the handshake and the tag pipe.
  - The INTT path reuses fermat_mod_mul.

Test Plan:
1. Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0 immediately, outputs 0. After release, none of the flushed tags ever appears.
2. a=1, b=2, psi=65536, tag=5 -> after 3 cycles: out0=65536, out1=3, out_tag=5.
3. a=65536, b=65536, psi=65536 -> out0=0, out1=65535 (wrap of sum to zero).
4. a=0, b=65536, psi=2 (product 2^17, reduction lo<hi) -> out0=65535, out1=2. Also a=0, b=5, psi=256 -> out0=1280, out1=64257.
5. Back-pressure: stream 8 ops with tags 0..7 while toggling out_ready pseudo-randomly -> all 8 results arrive in order. Outputs are stable during stalls, in_ready=0 whenever out_valid=1 and out_ready=0.
6. Full rate: in_valid=1 and out_ready=1 for 128 ops against a software reference mod 65537 -> 128 matching results in 130 cycles, no bubbles after the first output.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and modular correction helpers for the mod 65537 NTT datapath.
// Every helper expects operands in [0, 65536] and returns a result in the same range.
package ntt_pkg;

    localparam int DATA_W = 17;
    localparam int PROD_W = 2 * DATA_W;
    localparam int RED_W  = DATA_W + 1;

    localparam logic [RED_W-1:0] Q = 18'd65537;

    // One conditional subtract of q brings a+y back into range.
    function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        logic [RED_W-1:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= Q) ? DATA_W'(s - Q) : DATA_W'(s);
    endfunction

    function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        return (x >= y) ? (x - y) : DATA_W'({1'b0, x} + Q - {1'b0, y});
    endfunction

endpackage

// File: rtl/fermat_mod_mul.sv
// Modular multiply z = x*y mod (2^16+1): full product, then Fermat fold.
// Latency 2 cycles; both register stages advance only while en=1.
// No handshake of its own: the caller stalls it by dropping en.
module fermat_mod_mul
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] z
);

    logic [PROD_W-1:0] p;
    logic [15:0]       lo;
    logic [RED_W-1:0]  hi;
    logic [DATA_W-1:0] t;

    // 2^16 == -1 mod q, so p = hi*2^16 + lo reduces to lo - hi.
    assign lo = p[15:0];
    assign hi = p[PROD_W-1:16];

    always_comb begin
        t = '0;
        if ({2'b00, lo} >= hi)
            t = DATA_W'({2'b00, lo} - hi);
        else
            t = DATA_W'({2'b00, lo} + Q - hi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
            z <= '0;
        end else if (en) begin
            p <= {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
            z <= t;
        end
    end

endmodule

// File: rtl/ntt_butterfly.sv
// Cooley-Tukey butterfly mod 65537: out0 = a + b*psi, out1 = a - b*psi, tag passed through.
// Latency 3 cycles, one operation per cycle.
// Whole pipe freezes while out_valid=1 and out_ready=0; in_ready drops in that case.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int TAG_W = 7
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] psi,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [TAG_W-1:0]  out_tag
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [TAG_W-1:0]  tag;
    } side_t;

    logic              en;
    logic              v1;
    logic              v2;
    logic              v3;
    side_t             s1;
    side_t             s2;
    logic [DATA_W-1:0] t2;

    assign en        = out_ready | ~v3;
    assign in_ready  = en;
    assign out_valid = v3;

    fermat_mod_mul u_mul (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (b),
        .y   (psi),
        .z   (t2)
    );

    // Side data is delayed two stages to line up with the product t2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1      <= '0;
            s2      <= '0;
            out0    <= '0;
            out1    <= '0;
            out_tag <= '0;
        end else if (en) begin
            v1      <= in_valid;
            v2      <= v1;
            v3      <= v2;
            s1      <= '{a: a, tag: in_tag};
            s2      <= s1;
            out0    <= mod_add(s2.a, t2);
            out1    <= mod_sub(s2.a, t2);
            out_tag <= s2.tag;
        end
    end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly: stimulus pushes expected results, a monitor pops on each output transfer.
// Expected values come from directed constants or a plain mod-65537 arithmetic model.
module tb_ntt_butterfly;

    localparam longint QL = 65537;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] a;
    logic [16:0] b;
    logic [16:0] psi;
    logic [6:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out0;
    logic [16:0] out1;
    logic [6:0]  out_tag;

    typedef struct {
        logic [16:0] e0;
        logic [16:0] e1;
        logic [6:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tot = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   n_out = 0;
    int   last_out_cyc = 0;

    ntt_butterfly dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .psi       (psi),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out_tag   (out_tag)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        tot++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input longint av, input longint bv, input longint pv,
                                   input logic [6:0] tg);
        exp_t   e;
        longint pr;
        pr    = (bv * pv) % QL;
        e.e0  = 17'((av + pr) % QL);
        e.e1  = 17'((av - pr + QL) % QL);
        e.tag = tg;
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [16:0] rnd17();
        case ($urandom_range(0, 7))
            0:       return 17'd0;
            1:       return 17'd65536;
            2:       return 17'd65535;
            default: return 17'($urandom_range(0, 65536));
        endcase
    endfunction

    // Drives one operand set at posedge+1 and waits (bounded) for the transfer.
    task automatic issue(input logic [16:0] av, input logic [16:0] bv, input logic [16:0] pv,
                         input logic [6:0] tg, input exp_t e);
        int waited = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        psi      = pv;
        in_tag   = tg;
        #8;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #9;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic issue_rnd(input logic [6:0] tg);
        logic [16:0] av;
        logic [16:0] bv;
        logic [16:0] pv;
        av = rnd17();
        bv = rnd17();
        pv = rnd17();
        issue(av, bv, pv, tg, model(longint'(av), longint'(bv), longint'(pv), tg));
    endtask

    task automatic issue_dir(input logic [16:0] av, input logic [16:0] bv, input logic [16:0] pv,
                             input logic [6:0] tg, input logic [16:0] r0, input logic [16:0] r1);
        exp_t e;
        e.e0  = r0;
        e.e1  = r1;
        e.tag = tg;
        e.cyc = 0;
        issue(av, bv, pv, tg, e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk);
            #9;
            w++;
        end
        @(posedge clk);
        #9;
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: stall stability, in_ready during stalls, scoreboard pop on transfer.
    initial begin
        exp_t        e;
        logic        stalled;
        logic [16:0] h0;
        logic [16:0] h1;
        logic [6:0]  ht;
        stalled = 1'b0;
        h0 = '0;
        h1 = '0;
        ht = '0;
        forever begin
            @(posedge clk);
            #9;
            if (rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_out0", out0, h0);
                chk("stall_out1", out1, h1);
                chk("stall_tag", out_tag, ht);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                stalled = 1'b1;
                h0 = out0;
                h1 = out1;
                ht = out_tag;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("flushed_tag_seen", longint'(out_tag >= 7'd120), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out0", out0, e.e0);
                    chk("out1", out1, e.e1);
                    chk("out_tag", out_tag, e.tag);
                    if (rdy_mode == 0) chk("latency", cyc - e.cyc, 3);
                    n_out++;
                    last_out_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: no finish after 500000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_cyc;
        int n0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        psi      = '0;
        in_tag   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_out_tag", out_tag, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed corner values, including 65536 (== -1) operands.
        issue_dir(17'd1, 17'd2, 17'd65536, 7'd5, 17'd65536, 17'd3);
        issue_dir(17'd65536, 17'd65536, 17'd65536, 7'd6, 17'd0, 17'd65535);
        issue_dir(17'd0, 17'd65536, 17'd2, 7'd7, 17'd65535, 17'd2);
        issue_dir(17'd0, 17'd5, 17'd256, 7'd8, 17'd1280, 17'd64257);
        idle();
        drain();

        // Reset with three operations in flight and the output stalled.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        issue_rnd(7'd120);
        issue_rnd(7'd121);
        issue_rnd(7'd122);
        idle();
        #2;
        chk("pre_flush_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out0", out0, 0);
        chk("flush_out1", out1, 0);
        chk("flush_out_tag", out_tag, 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        rdy_mode = 0;
        #1;
        chk("flush_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("flush_no_output", out_valid, 0);

        // Back-pressure: 8 ops while out_ready toggles randomly.
        rdy_mode = 1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) issue_rnd(7'(i));
        idle();
        drain();
        chk("bp_count", n_out - n0, 8);

        // Random gaps on both sides.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            issue_rnd(7'($urandom_range(0, 119)));
        end
        idle();
        drain();

        // Full rate: 128 back-to-back ops with out_ready held high.
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        n0 = n_out;
        issue_rnd(7'd0);
        first_cyc = cyc;
        for (int i = 1; i < 128; i++) issue_rnd(7'(i % 120));
        idle();
        drain();
        chk("full_rate_count", n_out - n0, 128);
        chk("full_rate_span", last_out_cyc - first_cyc, 130);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
